// File: rtl/s_axi_regbank.sv
// AXI4-Lite slave register bank: NUM_RW byte-writable control registers followed by NUM_RO
// read-only status words in one map, with a one-cycle strobe per committed control write.
module s_axi_regbank #(
   parameter int unsigned NUM_RW = 8,
   parameter int unsigned NUM_RO = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                     S_AXI_ACLK,
   input  logic                     S_AXI_ARESETN,
   input  logic [ADDR_W-1:0]        S_AXI_LITE_AWADDR,
   input  logic                     S_AXI_LITE_AWVALID,
   output logic                     S_AXI_LITE_AWREADY,
   input  logic [DATA_W-1:0]        S_AXI_LITE_WDATA,
   input  logic [DATA_W/8-1:0]      S_AXI_LITE_WSTRB,
   input  logic                     S_AXI_LITE_WVALID,
   output logic                     S_AXI_LITE_WREADY,
   output logic [1:0]               S_AXI_LITE_BRESP,
   output logic                     S_AXI_LITE_BVALID,
   input  logic                     S_AXI_LITE_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_LITE_ARADDR,
   input  logic                     S_AXI_LITE_ARVALID,
   output logic                     S_AXI_LITE_ARREADY,
   output logic [DATA_W-1:0]        S_AXI_LITE_RDATA,
   output logic [1:0]               S_AXI_LITE_RRESP,
   output logic                     S_AXI_LITE_RVALID,
   input  logic                     S_AXI_LITE_RREADY,
   output logic [NUM_RW*DATA_W-1:0] ctrl_regs,
   output logic [NUM_RW-1:0]        wr_pulse,
   input  logic [NUM_RO*DATA_W-1:0] status_in
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = ADDR_W - 2;

   if (DATA_W != 32) begin : g_bad_data_w
      $error("s_axi_regbank: DATA_W must be 32");
   end
   if (NUM_RW + NUM_RO > (1 << IDX_W)) begin : g_bad_addr_w
      $error("s_axi_regbank: register map does not fit in ADDR_W");
   end

   logic              aw_held_q, w_held_q;
   logic [IDX_W-1:0]  aw_idx_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic [DATA_W-1:0] regs_q [NUM_RW];
   logic [NUM_RW-1:0] wr_pulse_q;

   logic              aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [31:0]       widx, ridx;
   logic [DATA_W-1:0] rd_word;
   logic              rd_ok;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^{S_AXI_LITE_AWADDR[1:0], S_AXI_LITE_ARADDR[1:0]};

   // Ready depends only on flops, so there is no VALID->READY combinational path.
   assign S_AXI_LITE_AWREADY = ~aw_held_q & ~bvalid_q;
   assign S_AXI_LITE_WREADY  = ~w_held_q & ~bvalid_q;
   assign S_AXI_LITE_ARREADY = ~rvalid_q;

   assign aw_hs  = S_AXI_LITE_AWVALID & S_AXI_LITE_AWREADY;
   assign w_hs   = S_AXI_LITE_WVALID & S_AXI_LITE_WREADY;
   assign ar_hs  = S_AXI_LITE_ARVALID & S_AXI_LITE_ARREADY;
   assign commit = aw_held_q & w_held_q & ~bvalid_q;
   assign widx   = 32'(aw_idx_q);
   assign ridx   = 32'(S_AXI_LITE_ARADDR[ADDR_W-1:2]);
   assign wr_ok  = widx < NUM_RW;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= S_AXI_LITE_AWADDR[ADDR_W-1:2];
         end else if (commit) begin
            aw_held_q <= 1'b0;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= S_AXI_LITE_WDATA;
            w_strb_q <= S_AXI_LITE_WSTRB;
         end else if (commit) begin
            w_held_q <= 1'b0;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? 2'b00 : 2'b10;
         end else if (bvalid_q && S_AXI_LITE_BREADY) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // The strobe fires on any committed control write, even with all byte enables low.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int unsigned k = 0; k < NUM_RW; k++) regs_q[k] <= '0;
         wr_pulse_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_RW; k++) begin
            wr_pulse_q[k] <= commit && (widx == k);
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (commit && (widx == k) && w_strb_q[b]) begin
                  regs_q[k][b*8 +: 8] <= w_data_q[b*8 +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      rd_ok   = 1'b0;
      for (int unsigned k = 0; k < NUM_RW; k++) begin
         if (ridx == k) begin
            rd_word = regs_q[k];
            rd_ok   = 1'b1;
         end
      end
      for (int unsigned k = 0; k < NUM_RO; k++) begin
         if (ridx == NUM_RW + k) begin
            rd_word = status_in[k*DATA_W +: DATA_W];
            rd_ok   = 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= 2'b00;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_word;
         rresp_q  <= rd_ok ? 2'b00 : 2'b10;
      end else if (rvalid_q && S_AXI_LITE_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_RW; k++) begin : g_pack
      assign ctrl_regs[k*DATA_W +: DATA_W] = regs_q[k];
   end

   assign wr_pulse          = wr_pulse_q;
   assign S_AXI_LITE_BVALID = bvalid_q;
   assign S_AXI_LITE_BRESP  = bresp_q;
   assign S_AXI_LITE_RVALID = rvalid_q;
   assign S_AXI_LITE_RDATA  = rdata_q;
   assign S_AXI_LITE_RRESP  = rresp_q;

endmodule

// File: tb/tb_s_axi_regbank.sv
// Directed bench for s_axi_regbank: handshake ordering, byte strobes, error responses,
// read/write back-pressure and reset abandonment, checked against hand-computed values.
module tb_s_axi_regbank;

   localparam int unsigned NUM_RW = 8;
   localparam int unsigned NUM_RO = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [7:0]           awaddr = '0;
   logic                 awvalid = 1'b0;
   logic                 awready;
   logic [31:0]          wdata = '0;
   logic [3:0]           wstrb = '0;
   logic                 wvalid = 1'b0;
   logic                 wready;
   logic [1:0]           bresp;
   logic                 bvalid;
   logic                 bready = 1'b0;
   logic [7:0]           araddr = '0;
   logic                 arvalid = 1'b0;
   logic                 arready;
   logic [31:0]          rdata;
   logic [1:0]           rresp;
   logic                 rvalid;
   logic                 rready = 1'b0;
   logic [NUM_RW*32-1:0] ctrl_regs;
   logic [NUM_RW-1:0]    wr_pulse;
   logic [NUM_RO*32-1:0] status_in = '0;

   int checks = 0;
   int failures = 0;
   int pulse_count = 0;
   int pc;
   logic [31:0] exp_reg [NUM_RW];

   s_axi_regbank #(
      .NUM_RW(NUM_RW),
      .NUM_RO(NUM_RO),
      .DATA_W(32),
      .ADDR_W(8)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_LITE_AWADDR(awaddr),
      .S_AXI_LITE_AWVALID(awvalid),
      .S_AXI_LITE_AWREADY(awready),
      .S_AXI_LITE_WDATA(wdata),
      .S_AXI_LITE_WSTRB(wstrb),
      .S_AXI_LITE_WVALID(wvalid),
      .S_AXI_LITE_WREADY(wready),
      .S_AXI_LITE_BRESP(bresp),
      .S_AXI_LITE_BVALID(bvalid),
      .S_AXI_LITE_BREADY(bready),
      .S_AXI_LITE_ARADDR(araddr),
      .S_AXI_LITE_ARVALID(arvalid),
      .S_AXI_LITE_ARREADY(arready),
      .S_AXI_LITE_RDATA(rdata),
      .S_AXI_LITE_RRESP(rresp),
      .S_AXI_LITE_RVALID(rvalid),
      .S_AXI_LITE_RREADY(rready),
      .ctrl_regs(ctrl_regs),
      .wr_pulse(wr_pulse),
      .status_in(status_in)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_pulse != '0) pulse_count++;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_regs();
      logic [255:0] v;
      for (int k = 0; k < NUM_RW; k++) v[k*32 +: 32] = exp_reg[k];
      return v;
   endfunction

   // First channel handshakes on the next edge, the other three edges later; returns at the
   // negedge right after the commit edge.
   task automatic split_write(input logic aw_first, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
      chk32("split_ready0", 32'({awready, wready}), 32'h3);
      if (aw_first) begin awvalid = 1'b1; awaddr = addr; end
      else begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (aw_first) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      else begin awvalid = 1'b1; awaddr = addr; end
      chk32("split_bvalid_early", 32'(bvalid), 32'd0);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk32("split_bvalid_precommit", 32'(bvalid), 32'd0);
      @(negedge clk);
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input string tag);
      int n = 0;
      awvalid = 1'b1; awaddr = addr;
      wvalid = 1'b1; wdata = data; wstrb = strb;
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      chk32({tag, "_accept"}, 32'(awready && wready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      chk32({tag, "_bvalid"}, 32'(bvalid), 32'd1);
      chk32({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
      int n = 0;
      arvalid = 1'b1; araddr = addr;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      chk32({tag, "_arready"}, 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      rready  = 1'b1;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      chk32({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      chk32({tag, "_rdata"}, rdata, exp_data);
      chk32({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NUM_RW; k++) exp_reg[k] = '0;
      repeat (3) @(negedge clk);
      chkv("rst_ctrl_regs", ctrl_regs, '0);
      chk32("rst_bvalid", 32'(bvalid), 32'd0);
      chk32("rst_rvalid", 32'(rvalid), 32'd0);
      chk32("rst_rdata", rdata, 32'd0);
      chk32("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk32("rst_readies", 32'({awready, wready, arready}), 32'h7);

      // AW leads W by three cycles, then W leads AW
      bready = 1'b1;
      split_write(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
      exp_reg[1] = 32'hDEADBEEF;
      chk32("awfirst_bvalid", 32'(bvalid), 32'd1);
      chk32("awfirst_bresp", 32'(bresp), 32'd0);
      chk32("awfirst_reg1", ctrl_regs[63:32], 32'hDEADBEEF);
      chk32("awfirst_pulse", 32'(wr_pulse), 32'h02);
      @(negedge clk);
      chk32("awfirst_pulse_end", 32'(wr_pulse), 32'd0);
      chk32("awfirst_bvalid_clr", 32'(bvalid), 32'd0);
      split_write(1'b0, 8'h0C, 32'hDEADBEEF, 4'hF);
      exp_reg[3] = 32'hDEADBEEF;
      chk32("wfirst_bvalid", 32'(bvalid), 32'd1);
      chk32("wfirst_bresp", 32'(bresp), 32'd0);
      chkv("wfirst_regs", ctrl_regs, model_regs());
      chk32("wfirst_pulse", 32'(wr_pulse), 32'h08);
      @(negedge clk);
      chk32("wfirst_pulse_end", 32'(wr_pulse), 32'd0);
      bready = 1'b0;

      // byte strobes
      axi_write(8'h08, 32'h11223344, 4'hF, 2'b00, "wr_reg2");
      axi_write(8'h08, 32'hAABBCCDD, 4'h5, 2'b00, "wr_reg2_strb");
      exp_reg[2] = 32'h11BB33DD;
      chk32("strb_reg2", ctrl_regs[95:64], 32'h11BB33DD);
      axi_read(8'h08, 32'h11BB33DD, 2'b00, "rd_reg2");
      axi_read(8'h06, 32'hDEADBEEF, 2'b00, "rd_reg1_lsbs");

      // read-only and unmapped targets
      pc = pulse_count;
      axi_write(8'h20, 32'hFFFFFFFF, 4'hF, 2'b10, "wr_ro");
      axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, 2'b10, "wr_unmapped");
      chkv("err_regs_unchanged", ctrl_regs, model_regs());
      chk32("err_no_pulse", 32'(pulse_count - pc), 32'd0);
      axi_read(8'hFC, 32'd0, 2'b10, "rd_unmapped");

      // status read with RREADY held low; status changes after the handshake must not leak
      status_in[31:0] = 32'hCAFE0001;
      arvalid = 1'b1;
      araddr  = 8'h20;
      chk32("st_arready", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      status_in[31:0] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         chk32("st_hold_rvalid", 32'(rvalid), 32'd1);
         chk32("st_hold_rdata", rdata, 32'hCAFE0001);
         chk32("st_hold_rresp", 32'(rresp), 32'd0);
         chk32("st_hold_arready", 32'(arready), 32'd0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      chk32("st_rvalid_clr", 32'(rvalid), 32'd0);
      chk32("st_arready_back", 32'(arready), 32'd1);
      rready = 1'b0;
      status_in[127:96] = 32'h5A5A0003;
      axi_read(8'h2C, 32'h5A5A0003, 2'b00, "rd_status3");

      // B back-pressure with a second write already presented
      chk32("bp_ready0", 32'({awready, wready}), 32'h3);
      awvalid = 1'b1; awaddr = 8'h10;
      wvalid = 1'b1; wdata = 32'h01020304; wstrb = 4'hF;
      @(negedge clk);
      awaddr = 8'h14;
      wdata  = 32'h0A0B0C0D;
      @(negedge clk);
      exp_reg[4] = 32'h01020304;
      chk32("bp_reg4", ctrl_regs[159:128], 32'h01020304);
      chk32("bp_pulse4", 32'(wr_pulse), 32'h10);
      for (int i = 0; i < 5; i++) begin
         chk32("bp_bvalid_hold", 32'(bvalid), 32'd1);
         chk32("bp_awready_low", 32'(awready), 32'd0);
         chk32("bp_wready_low", 32'(wready), 32'd0);
         @(negedge clk);
      end
      chk32("bp_bresp", 32'(bresp), 32'd0);
      bready = 1'b1;
      @(negedge clk);
      chk32("bp_bvalid_clr", 32'(bvalid), 32'd0);
      chk32("bp_readies_back", 32'({awready, wready}), 32'h3);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk32("bp2_bvalid_early", 32'(bvalid), 32'd0);
      @(negedge clk);
      exp_reg[5] = 32'h0A0B0C0D;
      chk32("bp2_bvalid", 32'(bvalid), 32'd1);
      chk32("bp2_bresp", 32'(bresp), 32'd0);
      chk32("bp2_pulse5", 32'(wr_pulse), 32'h20);
      chkv("bp2_regs", ctrl_regs, model_regs());
      @(negedge clk);
      chk32("bp2_bvalid_clr", 32'(bvalid), 32'd0);
      bready = 1'b0;

      // reset while AW is held and W is still pending
      pc = pulse_count;
      awvalid = 1'b1;
      awaddr  = 8'h00;
      @(negedge clk);
      awvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chkv("arst_async_clear", ctrl_regs, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chkv("arst_ctrl_regs", ctrl_regs, '0);
      chk32("arst_bvalid", 32'(bvalid), 32'd0);
      chk32("arst_readies", 32'({awready, wready, arready}), 32'h7);
      chk32("arst_no_pulse", 32'(pulse_count - pc), 32'd0);
      wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
      @(negedge clk);
      wvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk32("arst_aw_abandoned", 32'(bvalid), 32'd0);
      chkv("arst_regs_still_zero", ctrl_regs, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
